tl_ul_scratch_responder: RTL and testbench
==========================================

# tl_ul_scratch_responder

TileLink-UL responder (manager end) that serves single-beat Get, PutFullData and PutPartialData requests from a small register-file scratchpad. It answers every accepted A-channel request with exactly one D-channel response and denies unsupported or out-of-range requests. Responses pass through a 2-entry output queue so back-pressure on D never corrupts state. It sits behind the TL monitor on the same link and is its counterpart: the monitor checks the traffic, this block produces the responses.

## Interface
- DEPTH, 16: scratchpad words (32-bit); power of two, 2..256.
- ADDR_W, 30: A-channel address width.
- SOURCE_W, 7: source ID width.
- BASE, 30'h0: base byte address; aligned to DEPTH*4.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  reset: synchronous, active-low; one clock; sampled on the rising edge of clock.
- a_valid / a_ready  in / out  1 / 1  A handshake.
- a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get, other unsupported.
- a_param  in  3  ignored.
- a_size  in  4  log2 bytes.
- a_source  in  SOURCE_W  request ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid / d_ready  out / in  1 / 1  D handshake.
- d_opcode  out  3  0 AccessAck, 1 AccessAckData.
- d_param  out  2  always 0.
- d_size  out  4  echo of a_size.
- d_source  out  SOURCE_W  echo of a_source.
- d_denied  out  1  request rejected.
- d_corrupt  out  1  equals d_denied on AccessAckData, else 0.
- d_data  out  32  read data; 0 when denied or AccessAck.

## Operation
- Accept when a_valid && a_ready. a_ready = !reset_active && (count < 2) || (count == 2 && d_valid && d_ready) — pass-through on full+pop allowed.
- Decode per accepted request:
  - idx = a_address[IDX_W+1:2], IDX_W = log2(DEPTH).
  - hit = a_address[ADDR_W-1:IDX_W+2] == BASE[ADDR_W-1:IDX_W+2].
  - aligned = address low a_size bits zero.
  - ok = hit && aligned && a_size <= 2 && opcode in {0,1,4}.
- Put (0/1), ok: byte lanes with a_mask[i]=1 written with a_data[8i+7:8i] at the accept edge. Response: AccessAck, denied 0.
- Get, ok: d_data = mem[idx] as read in the accept cycle, all 4 lanes regardless of mask. Response: AccessAckData.
- Not ok, no write:
  - opcodes 2, 3, 4 → AccessAckData, denied 1, corrupt 1, data 0.
  - all other opcodes → AccessAck, denied 1.
- Response queue: 2-entry FIFO with wrap-around pointers and count 0..2. Push on accept, pop on d_valid && d_ready; simultaneous push and pop leave count unchanged. d_valid = (count != 0). Head fields held stable while d_valid && !d_ready.
- Ordering: responses return strictly in acceptance order. A Get accepted the cycle after a Put to the same word returns the new data.
- Scratchpad is not reset; contents are undefined until written.

## Timing
- While reset_n is low at the clock edge: count and pointers cleared; d_valid=0, a_ready=0. After reset, all d_* outputs are 0 with count 0.
- First edge with reset_n high: a_ready=1.
- Latency: request accepted at edge N → d_valid=1 in cycle N+1 if the queue was empty.
- Throughput: 1 request/cycle with d_ready held high.
- Full (count 2, no pop): a_ready=0.
- Reset asserted mid-traffic: queued responses are dropped. Writes already performed at earlier edges persist.

## Test plan
- Put then Get: PutFull addr BASE+0x8, mask 4'hF, data 32'hDEADBEEF, source 5 → AccessAck src 5 at N+1. Get same address, source 6 → AccessAckData 32'hDEADBEEF, denied 0.
- Partial write: PutPartial BASE+0x8, mask 4'b0010, data 32'h0000AA00 over DEADBEEF → subsequent Get returns 32'hDEADAAEF.
- Back-pressure: d_ready=0, issue 3 Gets → a_ready drops after 2 accepts, d fields stable. Raise d_ready → three responses in order with correct sources, third accepted in the pop cycle.
- Denial: Get at BASE+DEPTH*4 → AccessAckData denied 1 corrupt 1 data 0. Get size 3 → denied. Get size 2 at BASE+0x2 → denied. Opcode 6 → AccessAck denied 1. Memory unchanged for all.
- Streaming: 20 back-to-back Puts then 20 Gets with d_ready=1 → one response per cycle, data matches a reference model.
- Reset mid-operation: 2 responses queued, reset_n low 1 cycle → d_valid=0, then a_ready=1. Previously written data is readable.

Source files
------------

// File: rtl/tl_ul_scratch_responder.sv
// TileLink-UL manager serving single-beat Get/PutFull/PutPartial from a word scratchpad.
// Responses are buffered in a 2-entry queue so D-channel back-pressure never stalls decode state.
module tl_ul_scratch_responder #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned SOURCE_W = 7,
  parameter logic [ADDR_W-1:0] BASE = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [3:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [3:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [3:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
    logic [31:0]         data;
  } rsp_t;

  logic [31:0]      mem [DEPTH];
  rsp_t             q [2];
  rsp_t             head;
  rsp_t             new_rsp;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             aligned;
  logic             ok;
  logic             is_put;
  logic             is_get;
  logic             push;
  logic             pop;
  logic             unused_a_param;

  assign unused_a_param = ^a_param;

  always_comb begin
    idx    = a_address[IDX_W+1:2];
    hit    = (a_address[ADDR_W-1:IDX_W+2] == BASE[ADDR_W-1:IDX_W+2]);
    is_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    is_get = (a_opcode == 3'd4);
    case (a_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = ~a_address[0];
      4'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    ok = hit && aligned && (is_put || is_get);

    new_rsp         = '0;
    new_rsp.size    = a_size;
    new_rsp.source  = a_source;
    new_rsp.denied  = ~ok;
    if (ok) begin
      if (is_get) begin
        new_rsp.opcode = 3'd1;
        new_rsp.data   = mem[idx];
      end
    end else if (a_opcode inside {3'd2, 3'd3, 3'd4}) begin
      // Denied data-bearing requests report a corrupt, zeroed AccessAckData
      new_rsp.opcode  = 3'd1;
      new_rsp.corrupt = 1'b1;
    end
  end

  assign d_valid = (count != 2'd0);
  assign pop     = d_valid && d_ready;
  assign a_ready = reset_n && ((count < 2'd2) || (count == 2'd2 && d_valid && d_ready));
  assign push    = a_valid && a_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) q[wr_ptr] <= new_rsp;
  end

  always_ff @(posedge clock) begin
    if (push && ok && is_put) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  assign head      = q[rd_ptr];
  assign d_param   = '0;
  assign d_opcode  = d_valid ? head.opcode  : '0;
  assign d_size    = d_valid ? head.size    : '0;
  assign d_source  = d_valid ? head.source  : '0;
  assign d_denied  = d_valid ? head.denied  : 1'b0;
  assign d_corrupt = d_valid ? head.corrupt : 1'b0;
  assign d_data    = d_valid ? head.data    : '0;

endmodule

// File: tb/tb_tl_ul_scratch_responder.sv
// Self-checking bench for tl_ul_scratch_responder: directed vector table, hand sequences,
// and randomized traffic compared against a queue/array reference model.
module tb_tl_ul_scratch_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [29:0] BASE  = 30'h0;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [6:0]  src;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [6:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    req_t        r;
    logic [2:0]  eop;
    logic        eden;
    logic [31:0] edata;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [3:0]  a_size = '0;
  logic [6:0]  a_source = '0;
  logic [29:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [6:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  rsp_t        mq[$];
  logic [31:0] mem_m [DEPTH];
  vec_t        tbl[13];

  tl_ul_scratch_responder #(.DEPTH(16), .ADDR_W(30), .SOURCE_W(7), .BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: decode rules applied directly to the request
  task automatic model(input req_t r, output rsp_t o);
    int unsigned i;
    bit ok;
    i  = int'(r.addr[5:2]);
    ok = ((r.addr >> 6) == (BASE >> 6)) && (r.size <= 2) &&
         ((r.addr % (1 << r.size)) == 0) && (r.op inside {3'd0, 3'd1, 3'd4});
    o.size = r.size;
    o.src  = r.src;
    o.den  = !ok;
    o.cor  = 1'b0;
    o.data = '0;
    o.op   = 3'd0;
    if (ok && r.op == 3'd4) begin
      o.op   = 3'd1;
      o.data = mem_m[i];
    end else if (ok) begin
      for (int b = 0; b < 4; b++)
        if (r.mask[b]) mem_m[i][8*b +: 8] = r.data[8*b +: 8];
    end else if (r.op inside {3'd2, 3'd3, 3'd4}) begin
      o.op  = 3'd1;
      o.cor = 1'b1;
    end
  endtask

  task automatic check_d();
    chk("d_param", 32'(d_param), 32'd0);
    if (mq.size() == 0) begin
      chk("d_valid", 32'(d_valid), 32'd0);
    end else begin
      chk("d_valid",   32'(d_valid),   32'd1);
      chk("d_opcode",  32'(d_opcode),  32'(mq[0].op));
      chk("d_size",    32'(d_size),    32'(mq[0].size));
      chk("d_source",  32'(d_source),  32'(mq[0].src));
      chk("d_denied",  32'(d_denied),  32'(mq[0].den));
      chk("d_corrupt", 32'(d_corrupt), 32'(mq[0].cor));
      chk("d_data",    d_data,         mq[0].data);
    end
  endtask

  task automatic check_zero();
    chk("rst_d_valid",  32'(d_valid),   32'd0);
    chk("rst_d_opcode", 32'(d_opcode),  32'd0);
    chk("rst_d_size",   32'(d_size),    32'd0);
    chk("rst_d_source", 32'(d_source),  32'd0);
    chk("rst_d_denied", 32'(d_denied),  32'd0);
    chk("rst_d_corrupt",32'(d_corrupt), 32'd0);
    chk("rst_d_data",   d_data,         32'd0);
  endtask

  // One clock: drive, check a_ready, advance model across the edge, check D
  task automatic step(input bit v, input req_t r, input bit dr);
    bit   exp_rdy;
    bit   acc;
    rsp_t rsp;
    a_valid   = v;
    a_opcode  = r.op;
    a_size    = r.size;
    a_source  = r.src;
    a_address = r.addr;
    a_mask    = r.mask;
    a_data    = r.data;
    a_param   = 3'($urandom_range(0, 7));
    d_ready   = dr;
    #1;
    exp_rdy = reset_n && ((mq.size() < 2) || dr);
    chk("a_ready", 32'(a_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clock);
    if (!reset_n) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && dr) void'(mq.pop_front());
      if (acc) begin
        model(r, rsp);
        mq.push_back(rsp);
      end
    end
    #1;
    check_d();
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [3:0] size, input logic [6:0] src,
                              input logic [29:0] addr, input logic [3:0] mask, input logic [31:0] data);
    req_t r;
    r.op = op; r.size = size; r.src = src; r.addr = addr; r.mask = mask; r.data = data;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [29:0] a;
    int unsigned k;
    k = $urandom_range(0, 9);
    r.op   = (k < 3) ? 3'd0 : (k < 5) ? 3'd1 : (k < 8) ? 3'd4 : 3'($urandom_range(0, 7));
    r.size = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 3)) : 4'd2;
    r.src  = 7'($urandom);
    a = 30'($urandom_range(0, DEPTH - 1)) << 2;
    if ($urandom_range(0, 5) == 0) a = a | 30'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) a = a | (30'h40 << $urandom_range(0, 23));
    r.addr = a;
    r.mask = 4'($urandom);
    r.data = $urandom;
    return r;
  endfunction

  initial begin
    req_t idle;
    idle = mk(3'd0, 4'd0, 7'd0, 30'd0, 4'd0, 32'd0);

    tbl[0]  = '{mk(3'd0, 4'd2, 7'd5,  30'h8,  4'hF, 32'hDEADBEEF), 3'd0, 1'b0, 32'h0};
    tbl[1]  = '{mk(3'd4, 4'd2, 7'd6,  30'h8,  4'h0, 32'h0),        3'd1, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{mk(3'd1, 4'd2, 7'd7,  30'h8,  4'h2, 32'h0000AA00), 3'd0, 1'b0, 32'h0};
    tbl[3]  = '{mk(3'd4, 4'd2, 7'd8,  30'h8,  4'h0, 32'h0),        3'd1, 1'b0, 32'hDEADAAEF};
    tbl[4]  = '{mk(3'd4, 4'd2, 7'd9,  30'h40, 4'hF, 32'h0),        3'd1, 1'b1, 32'h0};
    tbl[5]  = '{mk(3'd4, 4'd3, 7'd10, 30'h8,  4'hF, 32'h0),        3'd1, 1'b1, 32'h0};
    tbl[6]  = '{mk(3'd4, 4'd2, 7'd11, 30'h2,  4'hF, 32'h0),        3'd1, 1'b1, 32'h0};
    tbl[7]  = '{mk(3'd6, 4'd2, 7'd12, 30'h8,  4'hF, 32'h12345678), 3'd0, 1'b1, 32'h0};
    tbl[8]  = '{mk(3'd4, 4'd0, 7'd13, 30'h9,  4'h2, 32'h0),        3'd1, 1'b0, 32'hDEADAAEF};
    tbl[9]  = '{mk(3'd0, 4'd1, 7'd14, 30'h9,  4'hF, 32'h0BADF00D), 3'd0, 1'b1, 32'h0};
    tbl[10] = '{mk(3'd2, 4'd2, 7'd15, 30'h8,  4'hF, 32'h0BADF00D), 3'd1, 1'b1, 32'h0};
    tbl[11] = '{mk(3'd1, 4'd2, 7'd16, 30'h48, 4'hF, 32'h0BADF00D), 3'd0, 1'b1, 32'h0};
    tbl[12] = '{mk(3'd4, 4'd2, 7'd17, 30'h8,  4'h0, 32'h0),        3'd1, 1'b0, 32'hDEADAAEF};

    @(posedge clock);
    #1;
    reset_n = 1'b0;
    step(1'b1, idle, 1'b1);
    step(1'b0, idle, 1'b1);
    check_zero();
    reset_n = 1'b1;

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, mk(3'd0, 4'd2, 7'(i), 30'(i * 4), 4'hF, $urandom), 1'b1);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].r, 1'b1);
      chk("tbl_opcode",  32'(d_opcode),  32'(tbl[i].eop));
      chk("tbl_denied",  32'(d_denied),  32'(tbl[i].eden));
      chk("tbl_corrupt", 32'(d_corrupt), 32'(tbl[i].eop == 3'd1 && tbl[i].eden));
      chk("tbl_source",  32'(d_source),  32'(tbl[i].r.src));
      chk("tbl_data",    d_data,         tbl[i].edata);
    end
    step(1'b0, idle, 1'b1);

    // Back-pressure: two fill the queue, third waits, then rides the pop cycle
    step(1'b1, mk(3'd4, 4'd2, 7'd30, 30'h8, 4'h0, 32'h0), 1'b0);
    step(1'b1, mk(3'd4, 4'd2, 7'd31, 30'hC, 4'h0, 32'h0), 1'b0);
    step(1'b1, mk(3'd4, 4'd2, 7'd32, 30'h10, 4'h0, 32'h0), 1'b0);
    step(1'b1, mk(3'd4, 4'd2, 7'd32, 30'h10, 4'h0, 32'h0), 1'b0);
    chk("bp_head_src", 32'(d_source), 32'd30);
    step(1'b1, mk(3'd4, 4'd2, 7'd32, 30'h10, 4'h0, 32'h0), 1'b1);
    chk("bp_second_src", 32'(d_source), 32'd31);
    step(1'b0, idle, 1'b1);
    chk("bp_third_src", 32'(d_source), 32'd32);
    step(1'b0, idle, 1'b1);
    chk("bp_drained", 32'(d_valid), 32'd0);

    // Streaming: 20 Puts then 20 Gets, one per cycle
    for (int i = 0; i < 20; i++)
      step(1'b1, mk(3'd0, 4'd2, 7'(i), 30'($urandom_range(0, DEPTH - 1)) << 2, 4'hF, $urandom), 1'b1);
    for (int i = 0; i < 20; i++)
      step(1'b1, mk(3'd4, 4'd2, 7'(64 + i), 30'($urandom_range(0, DEPTH - 1)) << 2, 4'h0, 32'h0), 1'b1);

    // Mixed random traffic with random back-pressure
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_req(), $urandom_range(0, 3) != 0);

    // Reset with two responses queued
    step(1'b1, mk(3'd4, 4'd2, 7'd40, 30'h8, 4'h0, 32'h0), 1'b0);
    step(1'b1, mk(3'd4, 4'd2, 7'd41, 30'h4, 4'h0, 32'h0), 1'b0);
    reset_n = 1'b0;
    step(1'b0, idle, 1'b0);
    check_zero();
    reset_n = 1'b1;
    step(1'b1, mk(3'd4, 4'd2, 7'd42, 30'h8, 4'h0, 32'h0), 1'b1);
    step(1'b1, mk(3'd4, 4'd2, 7'd43, 30'h3C, 4'h0, 32'h0), 1'b1);
    step(1'b0, idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
